// File: rtl/freq_div_pkg.sv
// Shared types and constants for the multi-channel frequency divider:
// mode encoding, reset divisor, per-channel config record and channel state.
package freq_div_pkg;

   localparam logic        MODE_PERIODIC = 1'b0;
   localparam logic        MODE_ONESHOT  = 1'b1;

   localparam int unsigned FD_DEF_DIV    = 32'd11999999;

   // Widest divisor a channel can hold; the shadow record is sized to this.
   localparam int          FD_DIV_W_MAX  = 32;

   typedef struct packed {
      logic [FD_DIV_W_MAX-1:0] div;
      logic                    mode;
   } chan_cfg_t;

   // CH_RUN: periodic counting, CH_ARMED: one-shot in flight,
   // CH_HALTED: one-shot finished, waiting for a new config.
   typedef enum logic [1:0] {
      CH_RUN    = 2'd0,
      CH_ARMED  = 2'd1,
      CH_HALTED = 2'd2
   } ch_state_t;

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: terminal-count counter, shadowed config with deferred
// apply, one-shot control, and the tick / divided clock / step counter outputs.
module freq_div_channel
   import freq_div_pkg::*;
#(
   parameter int          DIV_W   = 32,
   parameter int          CNT_W   = 4,
   parameter int unsigned DEF_DIV = FD_DEF_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             mode_i,
   output logic             pend_o,
   output logic             tick_o,
   output logic             clk_out_o,
   output logic [CNT_W-1:0] step_o,
   output logic [1:0]       state_o
);

   ch_state_t        state_q, state_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic [DIV_W-1:0] div_q, div_d;
   chan_cfg_t        shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic             terminal;
   logic             active;
   logic             apply;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CH_RUN;
         count_q   <= '0;
         div_q     <= DIV_W'(DEF_DIV);
         shadow_q  <= '0;
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
         clk_out_q <= 1'b0;
         step_q    <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
         step_q    <= step_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
      step_d    = step_q;
      apply     = 1'b0;
      terminal  = (count_q == div_q);
      active    = en_i && (state_q != CH_HALTED);

      if (wr_i) begin
         shadow_d.div  = FD_DIV_W_MAX'(div_i);
         shadow_d.mode = mode_i;
         pend_d        = 1'b1;
      end

      // pend_q only rises the cycle after accept, so a terminal count in the
      // accept cycle itself can never pick up the new config.
      if (clr_i) begin
         count_d   = '0;
         clk_out_d = 1'b0;
         step_d    = '0;
         apply     = pend_q;
      end else if (active) begin
         if (terminal) begin
            count_d   = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
            step_d    = step_q + 1'b1;
            apply     = pend_q;
            if (state_q == CH_ARMED) begin
               state_d = CH_HALTED;
            end
         end else begin
            count_d = count_q + 1'b1;
         end
      end else begin
         apply = pend_q;
      end

      if (apply) begin
         div_d   = shadow_q.div[DIV_W-1:0];
         count_d = '0;
         pend_d  = 1'b0;
         state_d = (shadow_q.mode == MODE_ONESHOT) ? CH_ARMED : CH_RUN;
      end
   end

   assign pend_o    = pend_q;
   assign tick_o    = tick_q;
   assign clk_out_o = clk_out_q;
   assign step_o    = step_q;
   assign state_o   = state_q;

endmodule

// File: rtl/multi_channel_freq_divider.sv
// NCH independent programmable dividers sharing one config port.
// Optional global phase-align clear input sync_clr when SYNC_CLR_EN is defined.
module multi_channel_freq_divider
   import freq_div_pkg::*;
#(
   parameter int          NCH     = 4,
   parameter int          DIV_W   = 32,
   parameter int          CNT_W   = 4,
   parameter int unsigned DEF_DIV = FD_DEF_DIV,
   parameter int          CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef SYNC_CLR_EN
   input  logic                 sync_clr,
`endif
   input  logic [NCH-1:0]       en,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_chan,
   input  logic [DIV_W-1:0]     cfg_div,
   input  logic                 cfg_mode,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH*CNT_W-1:0] step_cnt,
   output logic [NCH-1:0]       busy
);

   logic [NCH-1:0]        pend;
   logic [(1<<CH_W)-1:0]  pend_pad;
   logic                  cfg_fire;
   logic                  clr;

`ifdef SYNC_CLR_EN
   assign clr = sync_clr;
`else
   assign clr = 1'b0;
`endif

   // Handshake: a write transfers on any clock edge where cfg_valid && cfg_ready;
   // cfg_ready is low only while the addressed channel still holds an unapplied
   // write. Unpopulated channel indices read as ready and swallow the write.
   always_comb begin
      pend_pad          = '0;
      pend_pad[NCH-1:0] = pend;
   end

   assign cfg_ready = ~pend_pad[cfg_chan];
   assign cfg_fire  = cfg_valid && cfg_ready;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [1:0] ch_state;

      freq_div_channel #(
         .DIV_W   (DIV_W),
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en_i      (en[i]),
         .clr_i     (clr),
         .wr_i      (cfg_fire && (cfg_chan == CH_W'(i))),
         .div_i     (cfg_div),
         .mode_i    (cfg_mode),
         .pend_o    (pend[i]),
         .tick_o    (tick[i]),
         .clk_out_o (clk_out[i]),
         .step_o    (step_cnt[i*CNT_W +: CNT_W]),
         .state_o   (ch_state)
      );

      assign busy[i] = (ch_state == CH_ARMED);
   end

endmodule

// File: tb/tb_multi_channel_freq_divider.sv
// Directed self-checking bench for multi_channel_freq_divider (DEF_DIV=3).
// A second 3-channel instance exercises writes to an unpopulated channel index.
module tb_multi_channel_freq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_chan;
   logic [31:0] cfg_div;
   logic        cfg_mode;
   logic [3:0]  tick;
   logic [3:0]  clk_out;
   logic [15:0] step_cnt;
   logic [3:0]  busy;

   logic [2:0]  en_b;
   logic        cfg_valid_b;
   logic        cfg_ready_b;
   logic [1:0]  cfg_chan_b;
   logic [31:0] cfg_div_b;
   logic        cfg_mode_b;
   logic [2:0]  tick_b;
   logic [2:0]  clk_out_b;
   logic [11:0] step_cnt_b;
   logic [2:0]  busy_b;

`ifdef SYNC_CLR_EN
   logic        sync_clr;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_channel_freq_divider #(
      .NCH(4), .DIV_W(32), .CNT_W(4), .DEF_DIV(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef SYNC_CLR_EN
      .sync_clr  (sync_clr),
`endif
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_mode  (cfg_mode),
      .tick      (tick),
      .clk_out   (clk_out),
      .step_cnt  (step_cnt),
      .busy      (busy)
   );

   multi_channel_freq_divider #(
      .NCH(3), .DIV_W(32), .CNT_W(4), .DEF_DIV(3)
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
`ifdef SYNC_CLR_EN
      .sync_clr  (sync_clr),
`endif
      .en        (en_b),
      .cfg_valid (cfg_valid_b),
      .cfg_ready (cfg_ready_b),
      .cfg_chan  (cfg_chan_b),
      .cfg_div   (cfg_div_b),
      .cfg_mode  (cfg_mode_b),
      .tick      (tick_b),
      .clk_out   (clk_out_b),
      .step_cnt  (step_cnt_b),
      .busy      (busy_b)
   );

   // Reset is released #1 after an edge; the next edge is cycle c=1.
   task automatic do_reset(input logic [3:0] en_v);
      cfg_valid   = 1'b0;
      cfg_valid_b = 1'b0;
`ifdef SYNC_CLR_EN
      sync_clr    = 1'b0;
`endif
      rst  = 1'b1;
      en   = en_v;
      en_b = 3'b111;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0]  exp_t, exp_c;
      logic [15:0] exp_s;
      logic [3:0]  nb;
      int          n;
      cfg_valid = 1'b0;
      cfg_chan  = 2'd0;
      rst = 1'b1;
      en  = 4'hF;
      @(posedge clk); #1;
      n_vec++;
      if (tick !== 4'h0) begin
         n_err++; $display("FAIL reset_tick: got %h want %h", tick, 4'h0);
      end
      n_vec++;
      if (clk_out !== 4'h0) begin
         n_err++; $display("FAIL reset_clk_out: got %h want %h", clk_out, 4'h0);
      end
      n_vec++;
      if (step_cnt !== 16'h0) begin
         n_err++; $display("FAIL reset_step: got %h want %h", step_cnt, 16'h0);
      end
      n_vec++;
      if (busy !== 4'h0) begin
         n_err++; $display("FAIL reset_busy: got %h want %h", busy, 4'h0);
      end
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
      end
      rst = 1'b0;
      for (int c = 1; c <= 68; c++) begin
         @(posedge clk); #1;
         n     = c / 4;
         nb    = n[3:0];
         exp_t = (c % 4 == 0) ? 4'hF : 4'h0;
         exp_c = n[0] ? 4'hF : 4'h0;
         exp_s = {nb, nb, nb, nb};
         n_vec++;
         if (tick !== exp_t) begin
            n_err++; $display("FAIL run_tick c=%0d: got %h want %h", c, tick, exp_t);
         end
         n_vec++;
         if (clk_out !== exp_c) begin
            n_err++; $display("FAIL run_clk_out c=%0d: got %h want %h", c, clk_out, exp_c);
         end
         n_vec++;
         if (step_cnt !== exp_s) begin
            n_err++; $display("FAIL run_step c=%0d: got %h want %h", c, step_cnt, exp_s);
         end
      end
   endtask

   task automatic test_cfg_periodic();
      logic [3:0] exp_t;
      logic       exp_r;
      do_reset(4'hF);
      cfg_mode = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         cfg_valid = 1'b0;
         case (c)
            1: begin cfg_chan = 2'd1; cfg_div = 32'd1; cfg_valid = 1'b1; end
            2: begin cfg_chan = 2'd0; cfg_div = 32'd3; cfg_valid = 1'b1; end
            3: begin cfg_chan = 2'd1; cfg_div = 32'd0; cfg_valid = 1'b1; end
            4: cfg_chan = 2'd1;
            5: cfg_chan = 2'd0;
            7: begin cfg_chan = 2'd3; cfg_div = 32'd1; cfg_valid = 1'b1; end
            default: ;
         endcase
         #1;
         exp_r = !((c == 3) || (c >= 8 && c <= 11));
         exp_t[0] = (c % 4 == 0);
         exp_t[1] = (c >= 4) && (c % 2 == 0);
         exp_t[2] = (c % 4 == 0);
         exp_t[3] = (c == 4) || (c == 8) || (c == 12) || (c == 14) || (c == 16);
         n_vec++;
         if (cfg_ready !== exp_r) begin
            n_err++; $display("FAIL cfg_ready c=%0d: got %b want %b", c, cfg_ready, exp_r);
         end
         n_vec++;
         if (tick !== exp_t) begin
            n_err++; $display("FAIL cfg_tick c=%0d: got %h want %h", c, tick, exp_t);
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [3:0] exp_b;
      logic       exp_t, exp_c, exp_r;
      do_reset(4'hF);
      for (int c = 1; c <= 68; c++) begin
         @(posedge clk); #1;
         cfg_valid = 1'b0;
         if (c == 1) begin
            cfg_chan = 2'd2; cfg_div = 32'd5; cfg_mode = 1'b1; cfg_valid = 1'b1;
         end else if (c == 61) begin
            cfg_chan = 2'd2; cfg_div = 32'd0; cfg_mode = 1'b0; cfg_valid = 1'b1;
         end
         #1;
         exp_b = (c >= 4 && c <= 9) ? 4'b0100 : 4'b0000;
         exp_t = (c == 4) || (c == 10) || (c >= 64);
         exp_c = (c >= 4 && c < 10) || (c >= 64 && (c % 2 == 0));
         exp_r = !((c == 2) || (c == 3) || (c == 62));
         n_vec++;
         if (busy !== exp_b) begin
            n_err++; $display("FAIL os_busy c=%0d: got %h want %h", c, busy, exp_b);
         end
         n_vec++;
         if (tick[2] !== exp_t) begin
            n_err++; $display("FAIL os_tick c=%0d: got %b want %b", c, tick[2], exp_t);
         end
         n_vec++;
         if (clk_out[2] !== exp_c) begin
            n_err++; $display("FAIL os_clk_out c=%0d: got %b want %b", c, clk_out[2], exp_c);
         end
         n_vec++;
         if (cfg_ready !== exp_r) begin
            n_err++; $display("FAIL os_ready c=%0d: got %b want %b", c, cfg_ready, exp_r);
         end
         if (c == 60) begin
            n_vec++;
            if (step_cnt[11:8] !== 4'd2) begin
               n_err++; $display("FAIL os_step: got %0d want 2", step_cnt[11:8]);
            end
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_en_freeze();
      int         n0;
      logic [3:0] nb;
      logic       exp_t0, exp_t1, exp_c0;
      do_reset(4'hF);
      for (int c = 1; c <= 28; c++) begin
         @(posedge clk); #1;
         en = (c >= 6 && c <= 15) ? 4'hE : 4'hF;
         #1;
         n0     = ((c >= 4) ? 1 : 0) + ((c >= 18) ? ((c - 18) / 4 + 1) : 0);
         nb     = n0[3:0];
         exp_t0 = (c == 4) || (c >= 18 && ((c - 18) % 4 == 0));
         exp_t1 = (c % 4 == 0);
         exp_c0 = n0[0];
         n_vec++;
         if (tick[0] !== exp_t0) begin
            n_err++; $display("FAIL frz_tick0 c=%0d: got %b want %b", c, tick[0], exp_t0);
         end
         n_vec++;
         if (tick[1] !== exp_t1) begin
            n_err++; $display("FAIL frz_tick1 c=%0d: got %b want %b", c, tick[1], exp_t1);
         end
         n_vec++;
         if (clk_out[0] !== exp_c0) begin
            n_err++; $display("FAIL frz_clk_out0 c=%0d: got %b want %b", c, clk_out[0], exp_c0);
         end
         n_vec++;
         if (step_cnt[3:0] !== nb) begin
            n_err++; $display("FAIL frz_step0 c=%0d: got %0d want %0d", c, step_cnt[3:0], nb);
         end
      end
   endtask

   task automatic test_bad_chan();
      logic [2:0] exp_t;
      do_reset(4'hF);
      cfg_chan_b = 2'd3;
      cfg_div_b  = 32'd0;
      cfg_mode_b = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         cfg_valid_b = (c == 1);
         #1;
         exp_t = (c % 4 == 0) ? 3'b111 : 3'b000;
         n_vec++;
         if (cfg_ready_b !== 1'b1) begin
            n_err++; $display("FAIL bad_ready c=%0d: got %b want 1", c, cfg_ready_b);
         end
         n_vec++;
         if (tick_b !== exp_t) begin
            n_err++; $display("FAIL bad_tick c=%0d: got %h want %h", c, tick_b, exp_t);
         end
         n_vec++;
         if (busy_b !== 3'b000) begin
            n_err++; $display("FAIL bad_busy c=%0d: got %h want 0", c, busy_b);
         end
      end
      cfg_valid_b = 1'b0;
   endtask

   task automatic test_reset_pending();
      logic [3:0] exp_t;
      do_reset(4'hF);
      @(posedge clk); #1;
      cfg_chan = 2'd1; cfg_div = 32'd0; cfg_mode = 1'b0; cfg_valid = 1'b1;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++; $display("FAIL rp_ready_pre: got %b want 1", cfg_ready);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b0) begin
         n_err++; $display("FAIL rp_ready_pending: got %b want 0", cfg_ready);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++; $display("FAIL rp_ready_in_reset: got %b want 1", cfg_ready);
      end
      n_vec++;
      if (tick !== 4'h0) begin
         n_err++; $display("FAIL rp_tick_in_reset: got %h want 0", tick);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         exp_t = (c % 4 == 0) ? 4'hF : 4'h0;
         n_vec++;
         if (tick !== exp_t) begin
            n_err++; $display("FAIL rp_tick c=%0d: got %h want %h", c, tick, exp_t);
         end
         n_vec++;
         if (cfg_ready !== 1'b1) begin
            n_err++; $display("FAIL rp_ready c=%0d: got %b want 1", c, cfg_ready);
         end
      end
   endtask

`ifdef SYNC_CLR_EN
   task automatic test_sync_clr();
      logic [3:0] exp_t;
      do_reset(4'hF);
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         en       = (c <= 2) ? 4'b1101 : 4'hF;
         sync_clr = (c == 6);
         #1;
         if (c <= 6) begin
            exp_t = {(c == 4), (c == 4), (c == 6), (c == 4)};
         end else begin
            exp_t = (c == 11 || c == 15) ? 4'hF : 4'h0;
         end
         n_vec++;
         if (tick !== exp_t) begin
            n_err++; $display("FAIL sc_tick c=%0d: got %h want %h", c, tick, exp_t);
         end
         if (c == 7) begin
            n_vec++;
            if (clk_out !== 4'h0) begin
               n_err++; $display("FAIL sc_clk_out: got %h want 0", clk_out);
            end
            n_vec++;
            if (step_cnt !== 16'h0) begin
               n_err++; $display("FAIL sc_step: got %h want 0", step_cnt);
            end
         end
      end
      sync_clr = 1'b0;
   endtask
`endif

   initial begin
      rst         = 1'b1;
      en          = 4'h0;
      cfg_valid   = 1'b0;
      cfg_chan    = 2'd0;
      cfg_div     = 32'd0;
      cfg_mode    = 1'b0;
      en_b        = 3'b000;
      cfg_valid_b = 1'b0;
      cfg_chan_b  = 2'd0;
      cfg_div_b   = 32'd0;
      cfg_mode_b  = 1'b0;
`ifdef SYNC_CLR_EN
      sync_clr    = 1'b0;
`endif
      test_reset();
      test_cfg_periodic();
      test_oneshot();
      test_en_freeze();
      test_bad_chan();
      test_reset_pending();
`ifdef SYNC_CLR_EN
      test_sync_clr();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
